// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Also holds the combinational round-robin priority pick.
package rr_mux_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam logic [1:0]  RESET_LAST = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // The search runs from offset NUM_REQ down to 1. Each hit overwrites the
  // previous one, so the nearest requester after `last` is the one that wins.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         last);
    logic [1:0] idx;
    rr_pick = last;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4.sv
// Structural 4-to-1 single-bit multiplexer driven by the arbiter's s1/s0 selects.
module rr_mux_arbiter_mux4 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  assign out = (i0 & ~s1 & ~s0) |
               (i1 & ~s1 &  s0) |
               (i2 &  s1 & ~s0) |
               (i3 &  s1 &  s0);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one serial line among four requesters.
// Grants are held for a burst, capped at MAX_HOLD cycles, with one idle cycle between owners.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               busy,
  output logic               out,
  output logic [1:0]         owner_id
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [1:0]         sel, sel_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic [1:0]         last, last_n;
  logic [1:0]         pick;
  logic               mux_out;

  assign pick = rr_pick(req, last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      last     <= RESET_LAST;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      hold_cnt <= hold_cnt_n;
      last     <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    sel_n      = sel;
    hold_cnt_n = hold_cnt;
    last_n     = last;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n    = ST_GRANT;
          gnt_n      = NUM_REQ'(1) << pick;
          sel_n      = pick;
          hold_cnt_n = '0;
        end
      end
      ST_GRANT: begin
        // Release always returns through IDLE; sel is kept so owner_id shows the last owner.
        if (!req[sel] || hold_cnt == HOLD_LAST) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          last_n  = sel;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  rr_mux_arbiter_mux4 u_mux (
    .i0  (din[0]),
    .i1  (din[1]),
    .i2  (din[2]),
    .i3  (din[3]),
    .s0  (sel[0]),
    .s1  (sel[1]),
    .out (mux_out)
  );

  assign s0       = sel[0];
  assign s1       = sel[1];
  assign owner_id = sel;
  assign busy     = (state == ST_GRANT);
  assign out      = busy & mux_out;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter: one instance with MAX_HOLD=8 and one with MAX_HOLD=4.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       reset, reset4;
  logic [3:0] req, din, req4, din4;
  logic [3:0] gnt, gnt4;
  logic       s0, s1, busy, out, s0_4, s1_4, busy4, out4;
  logic [1:0] owner_id, owner_id4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .s0(s0), .s1(s1), .busy(busy), .out(out), .owner_id(owner_id)
  );

  rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset4), .req(req4), .din(din4), .gnt(gnt4),
    .s0(s0_4), .s1(s1_4), .busy(busy4), .out(out4), .owner_id(owner_id4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},  32'(gnt),  32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " out"},  32'(out),  32'h0);
  endtask

  task automatic check_grant(input string tag, input int w);
    check({tag, " gnt"},  32'(gnt),      32'(4'b0001 << w));
    check({tag, " busy"}, 32'(busy),     32'h1);
    check({tag, " sel"},  32'({s1, s0}), 32'(w));
    check({tag, " own"},  32'(owner_id), 32'(w));
  endtask

  initial begin
    int       order [5];
    logic [3:0] d;
    order = '{0, 1, 2, 3, 0};

    reset = 1'b1; reset4 = 1'b1;
    req = '0; din = 4'b1111; req4 = '0; din4 = '0;

    // Reset state, then five idle cycles with din high.
    tick();
    check_idle("rst");
    check("rst sel", 32'({s1, s0}), 32'h0);
    check("rst own", 32'(owner_id), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // Full rotation with all requesters active: 8 grant cycles plus 1 idle each.
    req = 4'b1111;
    din = 4'b1010;
    for (int r = 0; r < 5; r++) begin
      tick();
      for (int k = 0; k < 8; k++) begin
        check_grant("rot", order[r]);
        d = din;
        check("rot out", 32'(out), 32'(d[order[r]]));
        tick();
      end
      check_idle("rot gap");
      check("rot hold sel", 32'({s1, s0}), 32'(order[r]));
      if (r == 4) req = '0;
    end

    // Short burst from requester 2 with toggling data; last owner was 0.
    req = 4'b0100;
    din = 4'b0000;
    tick();
    check_grant("b2", 2);
    din = 4'b0100; #1 check("b2 out1", 32'(out), 32'h1);
    tick();
    din = 4'b0000; #1 check("b2 out0", 32'(out), 32'h0);
    tick();
    din = 4'b0100; #1 check("b2 out1b", 32'(out), 32'h1);
    req = 4'b0000;
    tick();
    check_idle("b2 rel");
    check("b2 own hold", 32'(owner_id), 32'h2);

    // Wrap-around: last=2, req 0 and 3 active gives 3.
    din = 4'b1111;
    req = 4'b1001;
    tick();
    check_grant("wrap", 3);
    tick();
    tick();
    check_grant("mid", 3);

    // Reset mid-burst clears immediately; requester 0 wins next.
    reset = 1'b1;
    tick();
    check_idle("rst mid");
    check("rst mid sel", 32'({s1, s0}), 32'h0);
    reset = 1'b0;
    tick();
    check_grant("post rst", 0);
    req = '0;
    tick();
    check_idle("post rst rel");

    // Sole requester 1 with MAX_HOLD=4: 4 grant cycles then 1 idle, repeating.
    reset4 = 1'b0;
    req4 = 4'b0010;
    din4 = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        check("h4 gnt",  32'(gnt4),        32'h2);
        check("h4 sel",  32'({s1_4, s0_4}), 32'h1);
        check("h4 out",  32'(out4),        32'h1);
        tick();
      end
      check("h4 gap gnt",  32'(gnt4),  32'h0);
      check("h4 gap busy", 32'(busy4), 32'h0);
      check("h4 gap out",  32'(out4),  32'h0);
    end
    req4 = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
